// File: rtl/gcd_unit.sv
// gcd_unit: parametrised GCD engine with a start/busy/done handshake.
//
// Handshake: start is a one-sided request. It is accepted only when the
// engine is IDLE and needs no ready response. busy is high for every RUN
// cycle. done is a single-cycle pulse, and ans/iters change on the same edge
// that raises done. start is ignored while busy or done and is never queued.
// abort only has an effect in RUN. It drops the computation without a done
// pulse and leaves ans/iters untouched.
//
// Build option: define GCD_BINARY_EN to replace the subtractive Euclid step
// with Stein's binary algorithm. The interface and results are the same in
// both builds; only the iteration count differs.
module gcd_unit #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  ans,
    output logic [ITER_W-1:0] iters
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Working operands, the RUN-cycle counter and the published results.
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  ans_q, ans_d;
    logic [ITER_W-1:0] iters_q, iters_d;

`ifdef GCD_BINARY_EN
    // Number of factors of two stripped from both operands.
    localparam int K_W = $clog2(WIDTH) + 1;
    logic [K_W-1:0] k_q, k_d;
`endif

    // Operand comparisons shared by the finish test and the step rules.
    logic             a_zero;
    logic             b_zero;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             finish;
    logic [ITER_W-1:0] cnt_inc;
    logic [WIDTH-1:0]  result;

    // Decode the finish condition, the saturating count and the final result.
    always_comb begin
        a_zero  = (a_q == '0);
        b_zero  = (b_q == '0);
        a_eq_b  = (a_q == b_q);
        a_gt_b  = (a_q > b_q);
        finish  = a_zero || b_zero || a_eq_b;
        cnt_inc = (cnt_q == {ITER_W{1'b1}}) ? cnt_q : cnt_q + ITER_W'(1);
`ifdef GCD_BINARY_EN
        // The true GCD never exceeds max(a,b), so this shift cannot overflow.
        result  = (a_zero ? b_q : a_q) << k_q;
`else
        result  = a_zero ? b_q : a_q;
`endif
    end

    // Next-state logic and datapath updates for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ans_d   = ans_q;
        iters_d = iters_q;
`ifdef GCD_BINARY_EN
        k_d     = k_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
`ifdef GCD_BINARY_EN
                    k_d     = '0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (abort) begin
                    // Abort wins over a finish that would happen this cycle.
                    state_d = S_IDLE;
                end else if (finish) begin
                    ans_d   = result;
                    iters_d = cnt_inc;
                    state_d = S_DONE;
                end else begin
`ifdef GCD_BINARY_EN
                    if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + K_W'(1);
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_gt_b) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
`else
                    // Only the larger operand is reduced, so there is no underflow.
                    if (a_gt_b) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ans_q   <= '0;
            iters_q <= '0;
`ifdef GCD_BINARY_EN
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ans_q   <= ans_d;
            iters_q <= iters_d;
`ifdef GCD_BINARY_EN
            k_q     <= k_d;
`endif
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        busy  = (state_q == S_RUN);
        done  = (state_q == S_DONE);
        ans   = ans_q;
        iters = iters_q;
    end

endmodule

// File: tb/tb_gcd_unit.sv
// Testbench for gcd_unit (WIDTH=16, ITER_W=16); follows GCD_BINARY_EN if defined.
module tb_gcd_unit;

  localparam int W  = 16;
  localparam int IW = 16;
  localparam int LIMIT = 4000;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  ans;
  logic [IW-1:0] iters;

  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  gcd_unit #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .ans   (ans),
    .iters (iters)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: greatest common divisor by the modulo form of Euclid
  function automatic logic [W-1:0] ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  // reference: RUN cycles needed, counting one cycle per step plus the finish cycle
  function automatic logic [IW-1:0] ref_iters(input int unsigned x, input int unsigned y);
    int unsigned n;
    n = 0;
    while (!(x == 0 || y == 0 || x == y)) begin
`ifdef GCD_BINARY_EN
      if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = x - y;
      else y = y - x;
`else
      if (x > y) x = x - y;
      else y = y - x;
`endif
      n++;
    end
    n++;
    if (n > (1 << IW) - 1) n = (1 << IW) - 1;
    return n[IW-1:0];
  endfunction

  // driver: one start, operands scrambled while busy, run until done
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int nbusy, output logic seen_done,
                        output logic busy_at_done, output logic done_after);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    nbusy = 0;
    seen_done = 1'b0;
    busy_at_done = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 16'd3;
    b = 16'd6;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (ans !== '0) begin n_fail++; $display("FAIL reset_ans got=%0d exp=0", ans); end
    n_checks++; if (iters !== '0) begin n_fail++; $display("FAIL reset_iters got=%0d exp=0", iters); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int nb;
    logic sd, bd, da;
    logic [IW-1:0] exp_it;
`ifdef GCD_BINARY_EN
    exp_it = 16'd6;
`else
    exp_it = 16'd3;
`endif
    run_op(16'd12, 16'd8, nb, sd, bd, da);
    n_checks++; if (sd !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", sd); end
    n_checks++; if (ans !== 16'd4) begin n_fail++; $display("FAIL basic_ans got=%0d exp=4", ans); end
    n_checks++; if (iters !== exp_it) begin n_fail++; $display("FAIL basic_iters got=%0d exp=%0d", iters, exp_it); end
    n_checks++; if (nb != int'(exp_it)) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", nb, exp_it); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", bd); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", da); end
  endtask

  task automatic test_zero_operands();
    logic [W-1:0] za[3];
    logic [W-1:0] zb[3];
    int nb;
    logic sd, bd, da;
    za = '{16'd0, 16'd0, 16'd9};
    zb = '{16'd5, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(za[i], zb[i], nb, sd, bd, da);
      n_checks++; if (sd !== 1'b1) begin n_fail++; $display("FAIL zero_done[%0d] got=%b exp=1", i, sd); end
      n_checks++; if (ans !== ref_gcd(za[i], zb[i])) begin n_fail++; $display("FAIL zero_ans[%0d] got=%0d exp=%0d", i, ans, ref_gcd(za[i], zb[i])); end
      n_checks++; if (iters !== 16'd1) begin n_fail++; $display("FAIL zero_iters[%0d] got=%0d exp=1", i, iters); end
    end
  endtask

  task automatic test_coprime();
    int nb;
    logic sd, bd, da;
    run_op(16'd35, 16'd64, nb, sd, bd, da);
    n_checks++; if (ans !== 16'd1) begin n_fail++; $display("FAIL coprime_ans got=%0d exp=1", ans); end
    n_checks++; if (iters !== ref_iters(35, 64)) begin n_fail++; $display("FAIL coprime_iters got=%0d exp=%0d", iters, ref_iters(35, 64)); end
  endtask

  task automatic test_abort();
    int nb;
    logic sd, bd, da, any_done;
    run_op(16'd12, 16'd8, nb, sd, bd, da);
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_checks++; if (ans !== 16'd4) begin n_fail++; $display("FAIL abort_ans_kept got=%0d exp=4", ans); end
    n_checks++; if (iters !== ref_iters(12, 8)) begin n_fail++; $display("FAIL abort_iters_kept got=%0d exp=%0d", iters, ref_iters(12, 8)); end
    any_done = done;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    n_checks++; if (any_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", any_done); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_checks++; if (ans !== '0) begin n_fail++; $display("FAIL rstmid_ans got=%0d exp=0", ans); end
    n_checks++; if (iters !== '0) begin n_fail++; $display("FAIL rstmid_iters got=%0d exp=0", iters); end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    int n_exp;
    n_exp = int'(ref_iters(21, 14));
    @(negedge clk);
    start = 1'b1;
    a = 16'd21;
    b = 16'd14;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pos.push_back(t);
        n_checks++; if (ans !== 16'd7) begin n_fail++; $display("FAIL b2b_ans got=%0d exp=7", ans); end
      end
    end
    start = 1'b0;
    n_checks++; if (pos.size() < 3) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp>=3", pos.size()); end
    for (int i = 1; i < pos.size(); i++) begin
      n_checks++;
      if (pos[i] - pos[i-1] != n_exp + 2) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", pos[i] - pos[i-1], n_exp + 2);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int nb;
    logic sd, bd, da;
    logic [W-1:0] av, bv, exp_ans;
    logic [IW-1:0] exp_it;
    for (int i = 0; i < 20; i++) begin
      av = W'($urandom_range(0, 1023));
      bv = W'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) av = '0;
      exp_q.push_back(ref_gcd(av, bv));
      exp_it = ref_iters(av, bv);
      run_op(av, bv, nb, sd, bd, da);
      exp_ans = exp_q.pop_front();
      n_checks++; if (sd !== 1'b1) begin n_fail++; $display("FAIL rand_done a=%0d b=%0d got=%b exp=1", av, bv, sd); end
      n_checks++; if (ans !== exp_ans) begin n_fail++; $display("FAIL rand_ans a=%0d b=%0d got=%0d exp=%0d", av, bv, ans, exp_ans); end
      n_checks++; if (iters !== exp_it) begin n_fail++; $display("FAIL rand_iters a=%0d b=%0d got=%0d exp=%0d", av, bv, iters, exp_it); end
      n_checks++; if (nb != int'(exp_it)) begin n_fail++; $display("FAIL rand_busy_cycles a=%0d b=%0d got=%0d exp=%0d", av, bv, nb, exp_it); end
      n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL rand_done_width a=%0d b=%0d got=%b exp=0", av, bv, da); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_zero_operands();
    test_coprime();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_unit.md
# gcd_unit

Parametrised Euclid GCD engine: accepts two unsigned WIDTH-bit operands on a start strobe, iterates one step per clock, then returns the greatest common divisor with a one-cycle done pulse. It succeeds the fixed 16-bit GCD datapath/controller pair and adds:

- width generalisation;
- a start/busy/done handshake;
- zero-operand handling;
- an abort;
- an iteration counter;
- an optional binary (Stein) mode.

It is used standalone on the Nexys4 demo top, with the result shown on the seven-segment display.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- ITER_W, 16, iteration counter width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- abort  input  1  cancel a running computation; sampled only in RUN
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- ans  output  WIDTH  last completed result, held until the next completion
- iters  output  ITER_W  RUN cycles used by the last completed computation, saturating

## Operation
- **States:** IDLE, RUN, DONE. Internal registers: A, B (WIDTH), counter (ITER_W), and in binary mode shift count k (clog2(WIDTH)+1 bits).
- **IDLE:**
  - start=1: A←a, B←b, counter←0, k←0, go to RUN.
  - start=0: stay in IDLE.
- **RUN, each cycle:** counter increments (saturating at all-ones), then the first matching rule applies:
  1. abort=1: go to IDLE. ans and iters are unchanged, no done pulse. abort takes priority over finishing.
  2. A==0, B==0 or A==B: finish. ans←(A==0 ? B : A), shifted left by k in binary mode. iters←counter+1 (saturating). Go to DONE.
  3. Subtractive step (default):
     - A>B: A←A−B.
     - otherwise: B←B−A.
- **DONE:**
  - done=1, busy=0.
  - Go to IDLE unconditionally. start is ignored in DONE.
- **start outside IDLE:** ignored. It does not queue.
- **Special cases:**
  - gcd(0,x)=x and gcd(x,0)=x.
  - gcd(0,0)=0, finishing in 1 RUN cycle.
- **Arithmetic:** unsigned. A subtraction is only performed on the larger operand, so there is never underflow.
- **Width:** ans is exactly WIDTH bits. In binary mode the left shift by k cannot overflow, because the true GCD ≤ max(a,b).

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, ans=0, iters=0; A, B, counter and k cleared.
- **Reset priority:** reset overrides every other input in every state. Reset mid-RUN abandons the computation with no done pulse.
- **Accepted start:** start=1 at rising edge e in IDLE gives busy=1 from e.
- **Completion:** a computation taking N RUN cycles produces:
  - busy high for N cycles;
  - done high for the single cycle after that;
  - ans and iters updated on the same edge that raises done.
- **Minimum start spacing:** N+2 cycles.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Subtractive worst case:** a=2^WIDTH−1, b=1 needs 2^WIDTH−1 RUN cycles. iters saturates if ITER_W is too small.

## Configuration
- **GCD_BINARY_EN undefined:** subtractive Euclid as above.
- **GCD_BINARY_EN defined:** the RUN step rule (rule 3) becomes Stein's algorithm, evaluated after the abort and finish checks:
  - both even: A←A>>1, B←B>>1, k←k+1;
  - else if A even: A←A>>1;
  - else if B even: B←B>>1;
  - else the larger of A and B ← larger − smaller.
- **Binary mode finish:** ans←(A==0 ? B : A)<<k.
- **Binary mode worst case:** O(WIDTH) cycles (≤2·WIDTH+2).
- **Invariants across modes:** the interface, handshake and results are identical in both modes; only the iters value differs.

## Test plan
- **Reset:** rst held 2 cycles, then released → busy=0, done=0, ans=0, iters=0. start pulsed during rst → ignored.
- **Basic GCD:** a=12, b=8, start → busy for 3 cycles, done pulse, ans=4, iters=3. With GCD_BINARY_EN: busy 6 cycles, ans=4, iters=6.
- **Zero operands, each started separately:**
  - a=0, b=5 → ans=5, iters=1;
  - a=0, b=0 → ans=0, iters=1;
  - a=9, b=0 → ans=9, iters=1.
- **Coprime operands:** a=35, b=64 → ans=1. Check both modes.
- **Abort and reset mid-run:**
  - a=65535, b=1; assert abort on the 10th RUN cycle → busy falls, no done, ans and iters keep their previous values.
  - Repeat with rst instead of abort → all outputs reset.
- **Handshake:**
  - start held high continuously with a=21, b=14 → ans=7; consecutive done pulses spaced exactly N+2=5 cycles apart.
  - Operand changes while busy → no effect on the result.
